fsm_debouncer: RTL

- Cleans one raw push-button input and produces the `tick` that drives the downstream `BCD_counter`.
- Sequence: 2-FF synchronizer → periodic sample strobe → 4-state debounce FSM.
- Outputs: a stable level plus a one-clock pulse per accepted press.
- Pulse is compatible with the counter's own level-to-edge handling (high one cycle, then low).

---
 rtl/fsm_debouncer_pkg.sv | 29 ++
 rtl/fsm_debouncer_sample_tick_gen.sv | 41 ++++
 rtl/fsm_debouncer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fsm_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debouncer_pkg
// Description : Shared types and default constants for the push-button
//               debouncer and its sample-strobe generator.
// Contents    : state_t debounce states, DEF_* parameter defaults, max2().
// Revision    : 1.0 - initial release
// ============================================================================
package debouncer_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  // 1 ms sample period at 100 MHz, 10 ms of stability to accept an edge.
  localparam int DEF_SAMPLE_DIV     = 100000;
  localparam int DEF_STABLE_SAMPLES = 10;
  localparam int DEF_REPEAT_DELAY   = 500;
  localparam int DEF_REPEAT_PERIOD  = 100;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_debouncer_sample_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : sample_tick_gen
// Description : Free-running mod-DIV counter producing a one-clock strobe
//               when the count equals DIV-1. Never paused; also usable as a
//               display-multiplex tick.
// Ports       : clk  - system clock (posedge)
//               rst  - asynchronous active-low reset (0 = reset)
//               samp - one-clock strobe every DIV clocks
// Revision    : 1.0 - initial release
// ============================================================================
module sample_tick_gen
  import debouncer_pkg::*;
#(
  parameter int DIV = DEF_SAMPLE_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic samp
);

  localparam int              c_cw   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(DIV - 1);

  logic [c_cw-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cw'(1);
    end
  end

  // Decoded straight from the count so the strobe lines up with the wrap.
  assign samp = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/fsm_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : fsm_debouncer
// Description : Push-button cleaner: 2-FF synchronizer, periodic sample
//               strobe and a 4-state debounce FSM. Produces a stable level
//               and a one-clock tick per accepted press.
// Options     : `define FSM_DEBOUNCER_AUTOREPEAT_EN adds auto-repeat ticks
//               while the button is held (REPEAT_DELAY / REPEAT_PERIOD, in
//               sample strobes).
// Ports       : clk      - system clock (posedge)
//               rst      - asynchronous active-low reset (0 = reset)
//               btn      - raw asynchronous button, active-high
//               db_level - debounced level
//               db_tick  - one-clock pulse per accepted press / repeat
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_debouncer
  import debouncer_pkg::*;
#(
  parameter int SAMPLE_DIV     = DEF_SAMPLE_DIV,
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD  = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic db_level,
  output logic db_tick
);

  // Parameter range guards (elaboration time only).
  if (SAMPLE_DIV < 2) begin : g_chk_sample_div
    $error("fsm_debouncer: SAMPLE_DIV must be >= 2");
  end
  if (STABLE_SAMPLES < 1) begin : g_chk_stable
    $error("fsm_debouncer: STABLE_SAMPLES must be >= 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_chk_repeat
    $error("fsm_debouncer: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  localparam int              c_sw          = $clog2(STABLE_SAMPLES + 1);
  localparam logic [c_sw-1:0] c_stable_last = c_sw'(STABLE_SAMPLES - 1);

  // --------------------------------------------------------------------------
  // Synchronizer
  // --------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;
  logic w_btn_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_btn_s = r_sync2;

  // --------------------------------------------------------------------------
  // Sample strobe
  // --------------------------------------------------------------------------
  logic w_samp;

  sample_tick_gen #(
    .DIV (SAMPLE_DIV)
  ) u_sample_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .samp (w_samp)
  );

  // --------------------------------------------------------------------------
  // Debounce FSM
  // --------------------------------------------------------------------------
  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_sw-1:0] r_cnt;
  logic [c_sw-1:0] w_cnt_nxt;
  logic            r_level;
  logic            r_tick;
  logic            w_press;
  logic            w_tick_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      LOW: begin
        if (w_btn_s) begin
          w_state_nxt = WAIT_HIGH;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        // A bounce is checked first so it beats a coincident strobe.
        if (!w_btn_s) begin
          w_state_nxt = LOW;
        end else if (w_samp) begin
          if (r_cnt == c_stable_last) begin
            w_state_nxt = HIGH;
          end else begin
            w_cnt_nxt = r_cnt + c_sw'(1);
          end
        end
      end
      HIGH: begin
        if (!w_btn_s) begin
          w_state_nxt = WAIT_LOW;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (w_btn_s) begin
          w_state_nxt = HIGH;
        end else if (w_samp) begin
          if (r_cnt == c_stable_last) begin
            w_state_nxt = LOW;
          end else begin
            w_cnt_nxt = r_cnt + c_sw'(1);
          end
        end
      end
      default: begin
        w_state_nxt = LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Only the WAIT_HIGH -> HIGH edge is a new press; WAIT_LOW -> HIGH is a
  // release glitch and stays silent.
  assign w_press = (r_state == WAIT_HIGH) && (w_state_nxt == HIGH);

`ifdef FSM_DEBOUNCER_AUTOREPEAT_EN
  // --------------------------------------------------------------------------
  // Auto-repeat: counts strobes while HIGH. The first repeat comes after
  // REPEAT_DELAY strobes, later ones every REPEAT_PERIOD strobes. State is
  // held across a release glitch (WAIT_LOW) and cleared once released.
  // --------------------------------------------------------------------------
  localparam int              c_rw           = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [c_rw-1:0] c_delay_last   = c_rw'(REPEAT_DELAY - 1);
  localparam logic [c_rw-1:0] c_period_last  = c_rw'(REPEAT_PERIOD - 1);

  logic [c_rw-1:0] r_rep;
  logic [c_rw-1:0] w_rep_nxt;
  logic            r_rep_armed;
  logic            w_rep_armed_nxt;
  logic            w_rep_fire;

  always_comb begin
    w_rep_nxt       = r_rep;
    w_rep_armed_nxt = r_rep_armed;
    w_rep_fire      = 1'b0;
    case (r_state)
      HIGH: begin
        // A strobe coinciding with the release does not count.
        if (w_samp && (w_state_nxt == HIGH)) begin
          if (r_rep == (r_rep_armed ? c_period_last : c_delay_last)) begin
            w_rep_fire      = 1'b1;
            w_rep_nxt       = '0;
            w_rep_armed_nxt = 1'b1;
          end else begin
            w_rep_nxt = r_rep + c_rw'(1);
          end
        end
      end
      WAIT_LOW: begin
        w_rep_nxt       = r_rep;
        w_rep_armed_nxt = r_rep_armed;
      end
      default: begin
        w_rep_nxt       = '0;
        w_rep_armed_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rep       <= '0;
      r_rep_armed <= 1'b0;
    end else begin
      r_rep       <= w_rep_nxt;
      r_rep_armed <= w_rep_armed_nxt;
    end
  end

  assign w_tick_nxt = w_press | w_rep_fire;
`else
  assign w_tick_nxt = w_press;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      // Registered from the next state so the level tracks r_state exactly.
      r_level <= (w_state_nxt == HIGH) || (w_state_nxt == WAIT_LOW);
      r_tick  <= w_tick_nxt;
    end
  end

  assign db_level = r_level;
  assign db_tick  = r_tick;

endmodule
`default_nettype wire
